// File: rtl/bf8b_mmio_pkg.sv
// Shared definitions for bf8b word-bus MMIO peripherals: timer register
// offsets, CTRL/STATUS bit positions and the byte-lane write merge.
package bf8b_mmio_pkg;

    // Default word address of timer register 0 (4-word aligned)
    localparam logic [29:0] TMR_BASE_ADDR_DEFAULT = 30'h0000_1000;

    // Timer register word offsets inside the 4-word window
    typedef enum logic [1:0] {
        TMR_CTRL    = 2'd0,
        TMR_COUNT   = 2'd1,
        TMR_COMPARE = 2'd2,
        TMR_STATUS  = 2'd3
    } tmr_reg_e;

    // CTRL bit positions
    localparam int CTRL_EN_BIT          = 0;
    localparam int CTRL_AUTO_RELOAD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT      = 2;
    localparam int CTRL_PRESCALE_LSB    = 8;
    localparam int CTRL_PRESCALE_MSB    = 15;

    // Implemented CTRL bits; everything else reads back as zero
    localparam logic [31:0] CTRL_RW_MASK = 32'h0000_FF07;

    // STATUS bit positions
    localparam int STATUS_MATCH_BIT = 0;
    localparam int STATUS_OVF_BIT   = 1;

    // Reset value of COMPARE: no match until software programs it
    localparam logic [31:0] COMPARE_RESET = 32'hFFFF_FFFF;

    // Replace the byte lanes selected by be with new_v, keep the rest of old_v
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mmio_prescaler.sv
// Clock prescaler for the MMIO timer: emits a one-cycle tick every
// (prescale+1) enabled cycles. Held at zero while disabled; a restart
// request (CTRL prescale byte written) starts a fresh period.
module mmio_prescaler (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_en,
    input  logic [7:0] i_prescale,
    input  logic       i_restart,
    output logic       o_tick
);

    logic [7:0] r_pcnt;
    logic       w_tick;

    // Tick fires on the cycle the period counter reaches the prescale value
    always_comb begin
        w_tick = i_en & (r_pcnt == i_prescale);
    end

    // Period counter: cleared when disabled, on restart and after each tick
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pcnt <= 8'd0;
        end else if (!i_en) begin
            r_pcnt <= 8'd0;
        end else if (i_restart || w_tick) begin
            r_pcnt <= 8'd0;
        end else begin
            r_pcnt <= r_pcnt + 8'd1;
        end
    end

    assign o_tick = w_tick;

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer on the bf8b CPU word bus. Four registers
// (CTRL, COUNT, COMPARE, STATUS) in a 4-word window at BASE_ADDR.
// Read data is registered (1-cycle latency) and zero when not selected,
// so it can be ORed with the RAM bank read data at the top level.
module mmio_timer
    import bf8b_mmio_pkg::*;
#(
    parameter logic [29:0] BASE_ADDR = TMR_BASE_ADDR_DEFAULT,
    parameter int          M_WIDTH   = 32   // only 32 is supported
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [29:0]        addr,
    input  logic [M_WIDTH-1:0] data_in,
    input  logic [3:0]         wes,
    output logic [M_WIDTH-1:0] data_out,
    output logic               irq
);

    // Architectural registers
    logic [31:0] r_ctrl;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic [1:0]  r_status;
    logic [31:0] r_rdata;

    // Bus decode
    logic        w_sel;
    tmr_reg_e    w_idx;
    logic        w_wr_ctrl;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_wr_status;
    logic        w_restart;

    // CTRL fields
    logic        w_en;
    logic        w_auto_reload;
    logic        w_irq_en;
    logic [7:0]  w_prescale;

    // Counter datapath
    logic        w_tick;
    logic        w_hit_match;
    logic        w_hit_ovf;
    logic [31:0] w_count_tick;
    logic [31:0] w_count_base;
    logic [31:0] w_count_nxt;
    logic [31:0] w_ctrl_nxt;
    logic [31:0] w_compare_nxt;
    logic [1:0]  w_status_clr;
    logic [1:0]  w_status_set;
    logic [1:0]  w_status_nxt;
    logic [31:0] w_rd_mux;

    // Address decode and per-register write strobes
    always_comb begin
        w_sel        = (addr[29:2] == BASE_ADDR[29:2]);
        w_idx        = tmr_reg_e'(addr[1:0]);
        w_wr_ctrl    = w_sel & (|wes) & (w_idx == TMR_CTRL);
        w_wr_count   = w_sel & (|wes) & (w_idx == TMR_COUNT);
        w_wr_compare = w_sel & (|wes) & (w_idx == TMR_COMPARE);
        w_wr_status  = w_sel & (|wes) & (w_idx == TMR_STATUS);
        // Any write touching the prescale byte starts a fresh prescale period
        w_restart    = w_sel & (w_idx == TMR_CTRL) & wes[1];
    end

    // CTRL field extraction
    always_comb begin
        w_en          = r_ctrl[CTRL_EN_BIT];
        w_auto_reload = r_ctrl[CTRL_AUTO_RELOAD_BIT];
        w_irq_en      = r_ctrl[CTRL_IRQ_EN_BIT];
        w_prescale    = r_ctrl[CTRL_PRESCALE_MSB:CTRL_PRESCALE_LSB];
    end

    mmio_prescaler u_prescaler (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_en       (w_en),
        .i_prescale (w_prescale),
        .i_restart  (w_restart),
        .o_tick     (w_tick)
    );

    // Counter next-state: tick advance/reload first, then CPU byte lanes on top
    always_comb begin
        w_hit_match  = w_tick & (r_count == r_compare);
        w_hit_ovf    = w_tick & (r_count == 32'hFFFF_FFFF);
        // All-ones wraps to zero through the +1, so reload and overflow agree
        if (w_hit_match && w_auto_reload) begin
            w_count_tick = 32'h0000_0000;
        end else begin
            w_count_tick = r_count + 32'd1;
        end
        if (w_tick) begin
            w_count_base = w_count_tick;
        end else begin
            w_count_base = r_count;
        end
        if (w_wr_count) begin
            w_count_nxt = byte_merge(w_count_base, data_in, wes);
        end else begin
            w_count_nxt = w_count_base;
        end
    end

    // CTRL/COMPARE/STATUS next-state; a flag set this cycle beats its W1C
    always_comb begin
        if (w_wr_ctrl) begin
            w_ctrl_nxt = byte_merge(r_ctrl, data_in, wes) & CTRL_RW_MASK;
        end else begin
            w_ctrl_nxt = r_ctrl;
        end
        if (w_wr_compare) begin
            w_compare_nxt = byte_merge(r_compare, data_in, wes);
        end else begin
            w_compare_nxt = r_compare;
        end
        if (w_wr_status && wes[0]) begin
            w_status_clr = data_in[1:0];
        end else begin
            w_status_clr = 2'b00;
        end
        w_status_set = {w_hit_ovf, w_hit_match};
        w_status_nxt = (r_status & ~w_status_clr) | w_status_set;
    end

    // Read mux over the pre-write register values
    always_comb begin
        case (w_idx)
            TMR_CTRL:    w_rd_mux = r_ctrl;
            TMR_COUNT:   w_rd_mux = r_count;
            TMR_COMPARE: w_rd_mux = r_compare;
            TMR_STATUS:  w_rd_mux = {30'h0000_0000, r_status};
            default:     w_rd_mux = 32'h0000_0000;
        endcase
    end

    // Register file update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl    <= 32'h0000_0000;
            r_count   <= 32'h0000_0000;
            r_compare <= COMPARE_RESET;
            r_status  <= 2'b00;
        end else begin
            r_ctrl    <= w_ctrl_nxt;
            r_count   <= w_count_nxt;
            r_compare <= w_compare_nxt;
            r_status  <= w_status_nxt;
        end
    end

    // Registered read data, zero when the window is not addressed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 32'h0000_0000;
        end else if (w_sel) begin
            r_rdata <= w_rd_mux;
        end else begin
            r_rdata <= 32'h0000_0000;
        end
    end

    assign data_out = r_rdata;
    // Both operands are flops, so the level interrupt cannot glitch
    assign irq      = r_status[STATUS_MATCH_BIT] & w_irq_en;

endmodule

// File: tb/tb_mmio_timer.sv
// Bench for mmio_timer: a behavioural model predicts the read data and irq
// for every bus cycle; a monitor compares them one clock later.
module tb_mmio_timer;

    localparam logic [29:0] BASE = 30'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic [31:0] data_in;
    logic [3:0]  wes;
    logic [31:0] data_out;
    logic        irq;

    always #5 clk = ~clk;

    mmio_timer #(.BASE_ADDR(BASE), .M_WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .wes      (wes),
        .data_out (data_out),
        .irq      (irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] m_ctrl;
    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic [1:0]  m_status;
    int          m_since_tick;   // enabled cycles since last tick/restart

    typedef struct packed {
        logic [31:0] d;
        logic        irq;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        m_ctrl       = 32'h0;
        m_count      = 32'h0;
        m_compare    = 32'hFFFF_FFFF;
        m_status     = 2'b00;
        m_since_tick = 0;
    endfunction

    function automatic logic [31:0] model_reg(input int idx);
        case (idx)
            0:       return m_ctrl;
            1:       return m_count;
            2:       return m_compare;
            default: return {30'h0, m_status};
        endcase
    endfunction

    // One bus cycle of the timer as described by its register rules
    function automatic void model_step(input logic [29:0] a, input logic [31:0] d, input logic [3:0] w);
        logic        sel;
        int          idx;
        logic [31:0] rd;
        logic        tick;
        logic        hit_m;
        logic        hit_o;
        logic [31:0] nctrl;
        logic [31:0] ncount;
        logic [31:0] ncompare;
        logic [1:0]  nstatus;
        longint      inc;
        sel   = (a[29:2] == BASE[29:2]);
        idx   = int'(a[1:0]);
        rd    = sel ? model_reg(idx) : 32'h0;
        tick  = m_ctrl[0] && (m_since_tick == int'(m_ctrl[15:8]));
        hit_m = 1'b0;
        hit_o = 1'b0;
        ncount = m_count;
        if (tick) begin
            hit_m = (m_count == m_compare);
            hit_o = (m_count == 32'hFFFF_FFFF);
            inc   = (longint'(m_count) + 64'd1) % 64'h1_0000_0000;
            ncount = (hit_m && m_ctrl[1]) ? 32'h0 : inc[31:0];
        end
        if (!m_ctrl[0] || tick || (sel && idx == 0 && w[1])) m_since_tick = 0;
        else m_since_tick = m_since_tick + 1;
        nctrl    = m_ctrl;
        ncompare = m_compare;
        nstatus  = m_status;
        if (sel) begin
            for (int i = 0; i < 4; i++) begin
                if (w[i]) begin
                    case (idx)
                        0: nctrl[8*i +: 8]    = d[8*i +: 8];
                        1: ncount[8*i +: 8]   = d[8*i +: 8];
                        2: ncompare[8*i +: 8] = d[8*i +: 8];
                        default: if (i == 0) nstatus = nstatus & ~d[1:0];
                    endcase
                end
            end
        end
        nctrl   = nctrl & 32'h0000_FF07;
        nstatus = nstatus | {hit_o, hit_m};
        m_ctrl    = nctrl;
        m_count   = ncount;
        m_compare = ncompare;
        m_status  = nstatus;
        exp_q.push_back('{d: rd, irq: nstatus[0] & nctrl[2]});
    endfunction

    // Drive one bus cycle at the falling edge and record its expected response
    task automatic cyc(input logic [29:0] a, input logic [31:0] d, input logic [3:0] w);
        @(negedge clk);
        addr    = a;
        data_in = d;
        wes     = w;
        model_step(a, d, w);
    endtask

    task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] w);
        cyc(BASE + 30'(idx), d, w);
    endtask

    // Read with an independent constant expectation
    task automatic rd_expect(input int idx, input logic [31:0] ev, input string name);
        cyc(BASE + 30'(idx), 32'h0, 4'h0);
        @(posedge clk);
        #2;
        chk(name, data_out, ev);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst  = 1'b0;
        addr = 30'h0;
        wes  = 4'h0;
        model_reset();
        #1;
        chk({name, "_rdata"}, data_out, 32'h0);
        chk({name, "_irq"}, {31'h0, irq}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Monitor: every clock with a pending expectation, compare the DUT outputs
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rdata", data_out, e.d);
            chk("irq", {31'h0, irq}, {31'h0, e.irq});
        end
    end

    initial begin
        logic [29:0] ra;
        logic [31:0] rd_v;
        logic [3:0]  rw;
        int          sel_k;
        rst = 1'b0; addr = 30'h0; data_in = 32'h0; wes = 4'h0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_rdata", data_out, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);
        rd_expect(2, 32'hFFFF_FFFF, "reset_compare");
        rd_expect(4, 32'h0, "outside_window");

        // Prescale 3: COUNT steps every 4 cycles, match when COUNT==5
        wr(2, 32'd5, 4'hF);
        wr(0, 32'h0000_0305, 4'hF);
        for (int k = 0; k < 100; k++) begin
            cyc(BASE + 30'd1, 32'h0, 4'h0);
            @(posedge clk);
            #2;
            if (irq) break;
        end
        chk("prescale_irq", {31'h0, irq}, 32'h1);
        rd_expect(1, 32'd6, "prescale_count_after_match");
        wr(0, 32'h0, 4'hF);
        wr(3, 32'h3, 4'h1);

        // Auto-reload 0,1,2,0,... then W1C drops irq
        wr(1, 32'h0, 4'hF);
        wr(2, 32'd2, 4'hF);
        wr(0, 32'h0000_0007, 4'hF);
        repeat (12) cyc(BASE + 30'd1, 32'h0, 4'h0);
        wr(0, 32'h0000_0006, 4'h1);
        @(posedge clk); #2;
        chk("reload_irq_set", {31'h0, irq}, 32'h1);
        wr(3, 32'h1, 4'h1);
        @(posedge clk); #2;
        chk("reload_irq_cleared", {31'h0, irq}, 32'h0);

        // Overflow: FFFF_FFFE -> FFFF_FFFF -> 0 (ovf) -> match at 0
        wr(1, 32'hFFFF_FFFE, 4'hF);
        wr(2, 32'h0, 4'hF);
        wr(3, 32'h3, 4'h1);
        wr(0, 32'h0000_0001, 4'hF);
        rd_expect(3, 32'h0, "ovf_status_k0");
        rd_expect(3, 32'h0, "ovf_status_k1");
        rd_expect(3, 32'h2, "ovf_status_k2");
        rd_expect(3, 32'h3, "ovf_status_k3");
        wr(0, 32'h0, 4'hF);

        // Byte-lane merge
        wr(1, 32'h1122_3344, 4'hF);
        wr(1, 32'hAABB_CCDD, 4'b0101);
        rd_expect(1, 32'h11BB_33DD, "byte_lanes");

        // Collision: W1C on the match-set cycle, COUNT write on a tick
        wr(2, 32'd3, 4'hF);
        wr(1, 32'h0, 4'hF);
        wr(3, 32'h3, 4'h1);
        wr(0, 32'h0000_0005, 4'hF);
        repeat (3) cyc(30'h0, 32'h0, 4'h0);
        wr(3, 32'h1, 4'h1);
        @(posedge clk); #2;
        chk("w1c_vs_set", {31'h0, irq}, 32'h1);
        wr(1, 32'h1234_5678, 4'hF);
        rd_expect(1, 32'h1234_5678, "count_write_on_tick");
        wr(0, 32'h0, 4'hF);

        // Randomised traffic, with one asynchronous reset in the middle
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset("mid_reset");
            sel_k = int'($urandom_range(0, 99));
            if (sel_k < 85)      ra = BASE + 30'($urandom_range(0, 3));
            else if (sel_k < 93) ra = BASE + 30'($urandom_range(4, 7));
            else                 ra = 30'($urandom);
            rw   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            rd_v = $urandom;
            if (ra == BASE && $urandom_range(0, 3) != 0) rd_v = rd_v & 32'h0000_0307;
            if ((ra == BASE + 30'd1 || ra == BASE + 30'd2) && $urandom_range(0, 1) == 0)
                rd_v = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7))
                                                   : 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            cyc(ra, rd_v, rw);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
